// File: rtl/hcms29xx_rx_if.sv
// HCMS-29xx device-side serial pins, as driven by the display controller.
interface hcms29xx_rx_if;
    logic ser_clk;
    logic ser_din;
    logic ser_rs;
    logic ser_ce_n;
    logic ser_rst_n;

    modport master (
        output ser_clk,
        output ser_din,
        output ser_rs,
        output ser_ce_n,
        output ser_rst_n
    );

    modport slave (
        input ser_clk,
        input ser_din,
        input ser_rs,
        input ser_ce_n,
        input ser_rst_n
    );
endinterface

// File: rtl/hcms29xx_rx.sv
// HCMS-29xx display receiver: oversamples the serial pins on clk and rebuilds
// the dot image plus the two control words, flagging frames of bad length.
module hcms29xx_rx #(
    parameter int N      = 2,
    parameter int UNIT_W = 20,
    parameter int UNIT_H = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    hcms29xx_rx_if.slave                ser,
    output logic [N*UNIT_W*UNIT_H-1:0]  pdataout,
    output logic [7:0]                  cw0,
    output logic [7:0]                  cw1,
    output logic                        frame_done,
    output logic                        cmd_done,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int L  = N * UNIT_W * UNIT_H;
    localparam int CW = ($clog2(L + 2) > 4) ? $clog2(L + 2) : 4;
    localparam logic [CW-1:0] DOT_LEN = CW'(L);
    localparam logic [CW-1:0] DOT_SAT = CW'(L + 1);
    localparam logic [CW-1:0] CMD_LEN = CW'(8);
    localparam logic [CW-1:0] CMD_SAT = CW'(9);

    typedef enum logic [1:0] {IDLE, SHIFT_DOT, SHIFT_CMD, COMMIT} state_e;

    state_e state_q, state_d;

    // Stage [1] is the synchronized copy; stage [2] is edge-detect history.
    logic [2:0] sclk_q, sce_q;
    logic [1:0] sdin_q, srs_q, srst_q;

    logic [L-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_rs_q, frame_rs_d;
    logic          pend_q, pend_d;
    logic          pend_rs_q, pend_rs_d;
    logic [L-1:0]  pdata_q, pdata_d;
    logic [7:0]    cw0_q, cw0_d, cw1_q, cw1_d;
    logic          frame_done_q, frame_done_d;
    logic          cmd_done_q, cmd_done_d;
    logic          frame_err_q, frame_err_d;

    logic clk_rise, ce_fall, ce_rise, dev_rst, in_frame, start, start_rs, capture;
    logic [7:0] cmd_word;

    assign clk_rise = sclk_q[1] & ~sclk_q[2];
    assign ce_fall  = ~sce_q[1] & sce_q[2];
    assign ce_rise  = sce_q[1] & ~sce_q[2];
    assign dev_rst  = ~srst_q[1];
    assign in_frame = (state_q == SHIFT_DOT) || (state_q == SHIFT_CMD);
    // A ce_n fall seen during COMMIT is parked in pend_q and started from IDLE.
    assign start    = ce_fall | pend_q;
    assign start_rs = pend_q ? pend_rs_q : srs_q[1];
    // ce_n must still be low in the sample that sees the ser_clk rise.
    assign capture  = in_frame & clk_rise & ~sce_q[1];
    assign cmd_word = sr_q[L-1 -: 8];

    // Pin synchronizers, cleared to the idle levels of the link
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            sce_q  <= '1;
            srst_q <= '1;
            sdin_q <= '0;
            srs_q  <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], ser.ser_clk};
            sce_q  <= {sce_q[1:0], ser.ser_ce_n};
            srst_q <= {srst_q[0], ser.ser_rst_n};
            sdin_q <= {sdin_q[0], ser.ser_din};
            srs_q  <= {srs_q[0], ser.ser_rs};
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: device reset wins from any state
    always_comb begin
        state_d = state_q;
        if (dev_rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:                 if (start) state_d = start_rs ? SHIFT_CMD : SHIFT_DOT;
                SHIFT_DOT, SHIFT_CMD: if (ce_rise) state_d = COMMIT;
                COMMIT:               state_d = IDLE;
                default:              state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: shift/count while open, length check and commit in COMMIT
    always_comb begin
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        frame_rs_d   = frame_rs_q;
        pend_d       = pend_q;
        pend_rs_d    = pend_rs_q;
        pdata_d      = pdata_q;
        cw0_d        = cw0_q;
        cw1_d        = cw1_q;
        frame_done_d = 1'b0;
        cmd_done_d   = 1'b0;
        frame_err_d  = 1'b0;
        if (dev_rst) begin
            sr_d       = '0;
            cnt_d      = '0;
            frame_rs_d = 1'b0;
            pend_d     = 1'b0;
            pend_rs_d  = 1'b0;
            pdata_d    = '0;
            cw0_d      = 8'h00;
            cw1_d      = 8'h80;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_d      = '0;
                        frame_rs_d = start_rs;
                        pend_d     = 1'b0;
                    end
                end
                SHIFT_DOT, SHIFT_CMD: begin
                    if (capture) begin
                        sr_d = {sdin_q[1], sr_q[L-1:1]};
                        if (cnt_q != ((state_q == SHIFT_CMD) ? CMD_SAT : DOT_SAT))
                            cnt_d = cnt_q + 1'b1;
                    end
                end
                COMMIT: begin
                    if (ce_fall) begin
                        pend_d    = 1'b1;
                        pend_rs_d = srs_q[1];
                    end
                    if (frame_rs_q) begin
                        if (cnt_q == CMD_LEN) begin
                            if (cmd_word[7]) cw1_d = cmd_word;
                            else             cw0_d = cmd_word;
                            cmd_done_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (cnt_q == DOT_LEN) begin
                        pdata_d      = sr_q;
                        frame_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q         <= '0;
            cnt_q        <= '0;
            frame_rs_q   <= 1'b0;
            pend_q       <= 1'b0;
            pend_rs_q    <= 1'b0;
            pdata_q      <= '0;
            cw0_q        <= 8'h00;
            cw1_q        <= 8'h80;
            frame_done_q <= 1'b0;
            cmd_done_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            frame_rs_q   <= frame_rs_d;
            pend_q       <= pend_d;
            pend_rs_q    <= pend_rs_d;
            pdata_q      <= pdata_d;
            cw0_q        <= cw0_d;
            cw1_q        <= cw1_d;
            frame_done_q <= frame_done_d;
            cmd_done_q   <= cmd_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign pdataout   = pdata_q;
    assign cw0        = cw0_q;
    assign cw1        = cw1_q;
    assign frame_done = frame_done_q;
    assign cmd_done   = cmd_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = in_frame;

endmodule

// File: tb/tb_hcms29xx_rx.sv
// Bench for hcms29xx_rx: drives the serial link at clk/4 and checks commits
// through an expected/observed event scoreboard.
module tb_hcms29xx_rx;

    localparam int N  = 2;
    localparam int UW = 20;
    localparam int UH = 8;
    localparam int L  = N * UW * UH;

    typedef struct packed {
        logic [2:0]   kind;   // {frame_err, cmd_done, frame_done}
        logic [L-1:0] img;
        logic [7:0]   c0;
        logic [7:0]   c1;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hcms29xx_rx_if sif ();

    logic [L-1:0] pdataout;
    logic [7:0]   cw0, cw1;
    logic         frame_done, cmd_done, frame_err, busy;

    hcms29xx_rx #(.N(N), .UNIT_W(UW), .UNIT_H(UH)) dut (
        .clk(clk), .rst(rst), .ser(sif.slave),
        .pdataout(pdataout), .cw0(cw0), .cw1(cw1),
        .frame_done(frame_done), .cmd_done(cmd_done), .frame_err(frame_err),
        .busy(busy)
    );

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    logic [L-1:0] m_img;
    logic [7:0]   m_cw0, m_cw1;

    // Observed commit events, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (!rst && (frame_done || cmd_done || frame_err))
            obs_q.push_back({frame_err, cmd_done, frame_done, pdataout, cw0, cw1});
    end

    function automatic ev_t mk(input logic [2:0] k);
        ev_t e;
        e.kind = k; e.img = m_img; e.c0 = m_cw0; e.c1 = m_cw1;
        return e;
    endfunction

    task automatic expect_cmd(input logic [7:0] w);
        if (w[7]) m_cw1 = w; else m_cw0 = w;
        exp_q.push_back(mk(3'b010));
    endtask

    task automatic expect_dot(input logic [L-1:0] img);
        m_img = img;
        exp_q.push_back(mk(3'b001));
    endtask

    task automatic expect_err();
        exp_q.push_back(mk(3'b100));
    endtask

    task automatic idle_pins();
        sif.ser_clk = 1'b0; sif.ser_din = 1'b0; sif.ser_rs = 1'b0;
        sif.ser_ce_n = 1'b1; sif.ser_rst_n = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        sif.ser_din = b;
        sif.ser_clk = 1'b0;
        repeat (2) @(negedge clk);
        sif.ser_clk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Opens a frame, sends nbits LSB-first and raises ce_n; caller is at a negedge.
    task automatic send_frame(input logic rs, input logic [L-1:0] data, input int nbits);
        sif.ser_clk = 1'b0; sif.ser_rs = rs; sif.ser_ce_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < nbits; i++) send_bit((i < L) ? data[i] : 1'b0);
        sif.ser_clk = 1'b0;
        repeat (2) @(negedge clk);
        sif.ser_ce_n = 1'b1;
    endtask

    task automatic wait_obs(input int n, output int lat);
        lat = 0;
        while (obs_q.size() < n && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [L-1:0] cmd_data(input logic [7:0] w);
        logic [L-1:0] d;
        d = '0;
        d[7:0] = w;
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_pins();
        m_img = '0; m_cw0 = 8'h00; m_cw1 = 8'h80;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pdataout, cw0, cw1} !== {m_img, m_cw0, m_cw1}) begin
            n_bad++;
            $display("FAIL reset_regs: got cw0=%h cw1=%h img=%h, required cw0=00 cw1=80 img=0", cw0, cw1, pdataout);
        end
        n_cmp++;
        if ({busy, frame_done, cmd_done, frame_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got busy/fd/cd/fe=%b, required 0000", {busy, frame_done, cmd_done, frame_err});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_cmd();
        ev_t e, o;
        int lat;
        expect_cmd(8'h4F);
        send_frame(1'b1, cmd_data(8'h4F), 8);
        wait_obs(1, lat);
        repeat (10) @(negedge clk);
        expect_cmd(8'h81);
        send_frame(1'b1, cmd_data(8'h81), 8);
        wait_obs(2, lat);
        repeat (10) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL cmd_event: got no event, required kind=%b cw0=%h cw1=%h", e.kind, e.c0, e.c1);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL cmd_event: got kind=%b cw0=%h cw1=%h, required kind=%b cw0=%h cw1=%h", o.kind, o.c0, o.c1, e.kind, e.c0, e.c1);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL cmd_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_dot();
        ev_t e, o;
        int lat;
        expect_dot({(L/8){8'hA5}});
        send_frame(1'b0, {(L/8){8'hA5}}, L);
        wait_obs(1, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL dot_latency: got %0d clk, required 4 clk", lat);
        end
        repeat (10) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL dot_event: got no event, required kind=%b", e.kind);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL dot_event: got kind=%b img=%h, required kind=%b img=%h", o.kind, o.img, e.kind, e.img);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL dot_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_bad_len();
        ev_t e, o;
        int lat;
        expect_err();
        send_frame(1'b0, ~{(L/8){8'hA5}}, L - 1);
        wait_obs(1, lat);
        repeat (10) @(negedge clk);
        expect_err();
        send_frame(1'b0, ~{(L/8){8'hA5}}, L + 1);
        wait_obs(2, lat);
        repeat (10) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL badlen_event: got no event, required kind=%b", e.kind);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL badlen_event: got kind=%b img=%h, required kind=%b img=%h", o.kind, o.img, e.kind, e.img);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL badlen_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_dev_rst();
        ev_t e, o;
        int lat;
        logic [L-1:0] p2;
        for (int i = 0; i < L; i += 32) p2[i +: 32] = $urandom();
        sif.ser_clk = 1'b0; sif.ser_rs = 1'b0; sif.ser_ce_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 100; i++) send_bit(p2[i]);
        sif.ser_rst_n = 1'b0;
        repeat (5) @(negedge clk);
        m_img = '0; m_cw0 = 8'h00; m_cw1 = 8'h80;
        n_cmp++;
        if ({pdataout, cw0, cw1, busy} !== {m_img, m_cw0, m_cw1, 1'b0}) begin
            n_bad++;
            $display("FAIL devrst_hold: got cw0=%h cw1=%h busy=%b img=%h, required cw0=00 cw1=80 busy=0 img=0", cw0, cw1, busy, pdataout);
        end
        sif.ser_clk = 1'b0; sif.ser_ce_n = 1'b1;
        repeat (5) @(negedge clk);
        sif.ser_rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL devrst_pulses: got %0d events during abort, required 0", obs_q.size());
            obs_q.delete();
        end
        n_cmp++;
        if ({pdataout, cw0, cw1} !== {m_img, m_cw0, m_cw1}) begin
            n_bad++;
            $display("FAIL devrst_regs: got cw0=%h cw1=%h img=%h, required cw0=00 cw1=80 img=0", cw0, cw1, pdataout);
        end
        expect_dot(p2);
        send_frame(1'b0, p2, L);
        wait_obs(1, lat);
        repeat (10) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL devrst_next: got no event, required kind=%b", e.kind);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL devrst_next: got kind=%b img=%h, required kind=%b img=%h", o.kind, o.img, e.kind, e.img);
                end
            end
        end
    endtask

    task automatic test_coincident();
        ev_t e, o;
        int lat;
        logic [7:0] w;
        w = 8'h3C;
        expect_cmd(w);
        sif.ser_clk = 1'b0; sif.ser_rs = 1'b1; sif.ser_ce_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        sif.ser_clk = 1'b0; sif.ser_din = 1'b1;
        repeat (2) @(negedge clk);
        sif.ser_clk = 1'b1; sif.ser_ce_n = 1'b1;
        wait_obs(1, lat);
        sif.ser_clk = 1'b0;
        repeat (10) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL coincident_event: got no event, required kind=%b cw0=%h", e.kind, e.c0);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL coincident_event: got kind=%b cw0=%h cw1=%h, required kind=%b cw0=%h cw1=%h", o.kind, o.c0, o.c1, e.kind, e.c0, e.c1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        int lat;
        expect_cmd(8'h05);
        expect_cmd(8'h92);
        send_frame(1'b1, cmd_data(8'h05), 8);
        repeat (3) @(negedge clk);
        send_frame(1'b1, cmd_data(8'h92), 8);
        wait_obs(2, lat);
        repeat (10) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL b2b_event: got no event, required kind=%b cw0=%h cw1=%h", e.kind, e.c0, e.c1);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL b2b_event: got kind=%b cw0=%h cw1=%h, required kind=%b cw0=%h cw1=%h", o.kind, o.c0, o.c1, e.kind, e.c0, e.c1);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_extra: got %0d extra events, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_async_reset();
        sif.ser_clk = 1'b0; sif.ser_rs = 1'b1; sif.ser_ce_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_busy_open: got busy=%b, required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (pdataout !== '0) begin
            n_bad++;
            $display("FAIL arst_img: got %h, required 0", pdataout);
        end
        n_cmp++;
        if ({cw0, cw1} !== 16'h0080) begin
            n_bad++;
            $display("FAIL arst_cw: got cw0=%h cw1=%h, required cw0=00 cw1=80", cw0, cw1);
        end
        n_cmp++;
        if ({busy, frame_done, cmd_done, frame_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL arst_flags: got busy/fd/cd/fe=%b, required 0000", {busy, frame_done, cmd_done, frame_err});
        end
        idle_pins();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_dot();
        test_bad_len();
        test_dev_rst();
        test_coincident();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
